// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, result
// status levels and default widths.
package div_ctrl_pkg;

    // Default operand width; the result bus is twice this.
    localparam int DIV_DATA_WIDTH = 32;
    // Iteration counter width; must be able to hold DIV_DATA_WIDTH.
    localparam int DIV_CNT_WIDTH  = 6;

    // Divider FSM states (2-bit encodings).
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Result status levels driven on ready.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Request levels on start.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU. One quotient bit is produced per
// cycle; signed operation divides magnitudes and fixes signs at the end.
// Result is {remainder, quotient} held while start stays high.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      signed_div,
    input  logic [DATA_WIDTH-1:0]     operand1,
    input  logic [DATA_WIDTH-1:0]     operand2,
    input  logic                      start,
    input  logic                      annul,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic                      ready
);

    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0]        ONE_W    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]        ZERO_W   = {DW{1'b0}};
    localparam logic [2*DW:0]        ZERO_DVD = {(2*DW+1){1'b0}};
    localparam logic [2*DW-1:0]      ZERO_RES = {(2*DW){1'b0}};
    localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DW - 1);

    // Registered state
    div_state_e              r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [2*DW:0]           r_dividend;
    logic [DW-1:0]           r_divisor;
    logic                    r_signed;
    logic                    r_sign1;
    logic                    r_sign2;
    logic [2*DW-1:0]         r_result;
    logic                    r_ready;

    // Next-state values
    div_state_e              w_state_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [2*DW:0]           w_dividend_nxt;
    logic [DW-1:0]           w_divisor_nxt;
    logic                    w_signed_nxt;
    logic                    w_sign1_nxt;
    logic                    w_sign2_nxt;
    logic [2*DW-1:0]         w_result_nxt;
    logic                    w_ready_nxt;

    // Datapath helpers
    logic [DW-1:0]           w_abs1;
    logic [DW-1:0]           w_abs2;
    logic [DW:0]             w_diff;
    logic [DW-1:0]           w_quo_raw;
    logic [DW-1:0]           w_rem_raw;
    logic [DW-1:0]           w_quo_fix;
    logic [DW-1:0]           w_rem_fix;

    // Operand magnitudes; negation only applies to signed requests.
    always_comb begin
        w_abs1 = operand1;
        w_abs2 = operand2;
        if (signed_div && operand1[DW-1]) begin
            w_abs1 = (~operand1) + ONE_W;
        end else begin
            w_abs1 = operand1;
        end
        if (signed_div && operand2[DW-1]) begin
            w_abs2 = (~operand2) + ONE_W;
        end else begin
            w_abs2 = operand2;
        end
    end

    // Trial subtraction of the divisor from the upper partial remainder;
    // bit DW set means the divisor did not fit.
    assign w_diff = {1'b0, r_dividend[2*DW-1:DW]} - {1'b0, r_divisor};

    // Raw quotient/remainder as they sit in the shift register at the end.
    assign w_quo_raw = r_dividend[DW-1:0];
    assign w_rem_raw = r_dividend[2*DW:DW+1];

    // Sign correction: quotient follows sign1^sign2, remainder follows the dividend.
    always_comb begin
        w_quo_fix = w_quo_raw;
        w_rem_fix = w_rem_raw;
        if (r_signed && (r_sign1 ^ r_sign2)) begin
            w_quo_fix = (~w_quo_raw) + ONE_W;
        end else begin
            w_quo_fix = w_quo_raw;
        end
        if (r_signed && r_sign1) begin
            w_rem_fix = (~w_rem_raw) + ONE_W;
        end else begin
            w_rem_fix = w_rem_raw;
        end
    end

    // FSM next-state and datapath next-value logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_signed_nxt   = r_signed;
        w_sign1_nxt    = r_sign1;
        w_sign2_nxt    = r_sign2;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            DIV_FREE: begin
                w_result_nxt = ZERO_RES;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                if ((start == DIV_START) && !annul) begin
                    w_signed_nxt  = signed_div;
                    w_sign1_nxt   = operand1[DW-1];
                    w_sign2_nxt   = operand2[DW-1];
                    w_divisor_nxt = w_abs2;
                    if (operand2 == ZERO_W) begin
                        w_state_nxt = DIV_BY_ZERO;
                    end else begin
                        w_state_nxt    = DIV_ON;
                        w_cnt_nxt      = ZERO_CNT;
                        w_dividend_nxt = {ZERO_W, w_abs1, 1'b0};
                    end
                end else begin
                    w_state_nxt = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                if (annul) begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = ZERO_RES;
                end else begin
                    w_dividend_nxt = ZERO_DVD;
                    w_state_nxt    = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul) begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = ZERO_RES;
                end else begin
                    if (w_diff[DW]) begin
                        w_dividend_nxt = {r_dividend[2*DW-1:0], 1'b0};
                    end else begin
                        w_dividend_nxt = {w_diff[DW-1:0], r_dividend[DW-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + ONE_CNT;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = DIV_END;
                    end else begin
                        w_state_nxt = DIV_ON;
                    end
                end
            end

            DIV_END: begin
                if (annul) begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = ZERO_RES;
                end else if (start == DIV_START) begin
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = DIV_RESULT_READY;
                end else begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = ZERO_RES;
                end
            end

            default: begin
                w_state_nxt  = DIV_FREE;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                w_result_nxt = ZERO_RES;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= DIV_FREE;
            r_cnt      <= ZERO_CNT;
            r_dividend <= ZERO_DVD;
            r_divisor  <= ZERO_W;
            r_signed   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= ZERO_RES;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_signed   <= w_signed_nxt;
            r_sign1    <= w_sign1_nxt;
            r_sign2    <= w_sign2_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result = r_result;
    assign ready  = r_ready;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected result and ready
// cycle, an independent monitor compares on each rising ready.
module tb_div_ctrl;

    logic        clock;
    logic        reset;
    logic        signed_div;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          at_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic prev_ready = 1'b0;

    div_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .signed_div (signed_div),
        .operand1   (operand1),
        .operand2   (operand2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every rising ready must match the oldest pending expectation.
    always @(negedge clock) begin
        if (ready && !prev_ready) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_ready: result=%h with no pending request", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result !== e.res) begin
                    failures = failures + 1;
                    $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
                end
                checks = checks + 1;
                if (cyc != e.at_cyc) begin
                    failures = failures + 1;
                    $display("FAIL %s latency: ready at cycle %0d expected %0d", e.name, cyc, e.at_cyc);
                end
            end
        end
        prev_ready = ready;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Full request: launch, scramble inputs after the start edge, wait for
    // ready, hold one cycle, drop start and confirm the output clears.
    task automatic do_op(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        exp_t e;
        @(negedge clock);
        signed_div = s;
        operand1   = a;
        operand2   = b;
        start      = 1'b1;
        @(posedge clock);
        #1;
        e.res    = exp;
        e.at_cyc = cyc + lat;
        e.name   = name;
        sb_q.push_back(e);
        @(negedge clock);
        operand1   = ~a;
        operand2   = 32'h0000_0003;
        signed_div = ~s;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clock);
            n = n + 1;
        end
        checks = checks + 1;
        if (!ready) begin
            failures = failures + 1;
            $display("FAIL %s timeout: ready=%b expected 1 within 60 cycles", name, ready);
        end
        @(negedge clock);
        chk({name, "_held_ready"}, {63'd0, ready}, 64'd1);
        chk({name, "_held_result"}, result, exp);
        start = 1'b0;
        @(negedge clock);
        chk({name, "_drop_ready"}, {63'd0, ready}, 64'd0);
        chk({name, "_drop_result"}, result, 64'd0);
    endtask

    initial begin
        int quiet;
        reset      = 1'b1;
        signed_div = 1'b0;
        operand1   = 32'd0;
        operand2   = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        reset = 1'b0;

        do_op("divu_7_2",    1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 33);
        do_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
        do_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33);
        do_op("divu_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33);
        do_op("divu_msb_2",  1'b0, 32'h8000_0001,  32'd2,          64'h00000001_40000000, 33);
        do_op("div_5_0",     1'b1, 32'd5,          32'd0,          64'h00000000_00000000, 2);

        // start together with annul while idle must not launch
        @(negedge clock);
        operand1 = 32'd9; operand2 = 32'd3; signed_div = 1'b0;
        start = 1'b1; annul = 1'b1;
        @(negedge clock);
        start = 1'b0; annul = 1'b0;
        repeat (40) @(negedge clock);
        chk("start_annul_no_launch", {63'd0, ready}, 64'd0);

        // annul on the tenth cycle of the iteration
        @(negedge clock);
        operand1 = 32'd100; operand2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clock);
        annul = 1'b1; start = 1'b0;
        @(negedge clock);
        annul = 1'b0;
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ready) quiet = 0;
        end
        chk("annul_no_ready", {63'd0, 1'(quiet)}, 64'd1);
        do_op("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);

        // asynchronous reset in the middle of an operation
        @(negedge clock);
        operand1 = 32'd1000; operand2 = 32'd3; signed_div = 1'b1; start = 1'b1;
        repeat (12) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midop_reset_ready", {63'd0, ready}, 64'd0);
        chk("midop_reset_result", result, 64'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("midop_reset_quiet", {63'd0, ready}, 64'd0);

        do_op("div_min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_ctrl
